// File: rtl/usb_if_pkg.sv
// Shared definitions for the USB data-port command path: command and
// response word layout, decoder state encoding and default bus timeout.
package usb_if_pkg;

  // Command word layout: {we, address, write data}
  localparam int CMD_WE_BIT  = 31;
  localparam int CMD_ADR_HI  = 30;
  localparam int CMD_ADR_LO  = 16;
  localparam int CMD_DAT_HI  = 15;
  localparam int CMD_DAT_LO  = 0;

  // Response word reuses the address/data lanes; bit 31 flags a failure
  localparam int RSP_ERR_BIT = 31;

  // Wishbone wait cycles tolerated before a transaction is abandoned
  localparam int DEF_TIMEOUT = 255;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_WB    = 3'd3,
    ST_RESP  = 3'd4,
    ST_PUSH  = 3'd5
  } dec_state_t;

endpackage

// File: rtl/dpi_cmd_dec.sv
// Data-port-IN command decoder: pops 32-bit command words, runs each as one
// 16-bit Wishbone transaction and returns read data / error reports as
// 32-bit words on the data-port-OUT FIFO.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a command word in the input FIFO
// FETCH | read strobe to the input FIFO (one cycle)
// LATCH | FIFO data valid; captured into the Wishbone request regs
// WB    | strobe on the bus, waiting for ack/err or timeout
// RESP  | response word held, waiting for room in the output FIFO
// PUSH  | output write strobe asserted for one cycle
module dpi_cmd_dec
  import usb_if_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        dpi_empty_i,
  output logic        dpi_rd_o,
  input  logic [31:0] dpi_dt_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [14:0] wb_adr_o,
  output logic [15:0] wb_dat_o,
  input  logic [15:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        dpo_full_i,
  output logic        dpo_wr_o,
  output logic [31:0] dpo_dt_o,
  output logic        busy_o,
  output logic [15:0] err_cnt_o
);

  localparam logic [15:0] TMO = 16'(TIMEOUT);

  dec_state_t  state;
  dec_state_t  state_nxt;
  logic [15:0] wait_cnt;
  logic [15:0] wait_nxt;
  logic [15:0] wait_inc;
  logic        rsp_load;
  logic        rsp_err;
  logic [31:0] rsp_word;

  assign wait_inc = wait_cnt + 16'd1;

  // Next-state logic; ack beats timeout, err beats ack
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    rsp_load  = 1'b0;
    rsp_err   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!dpi_empty_i) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        state_nxt = ST_LATCH;
      end
      ST_LATCH: begin
        state_nxt = ST_WB;
        wait_nxt  = '0;
      end
      ST_WB: begin
        if (wb_err_i) begin
          state_nxt = ST_RESP;
          rsp_load  = 1'b1;
          rsp_err   = 1'b1;
        end else if (wb_ack_i) begin
          if (wb_we_o) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_RESP;
            rsp_load  = 1'b1;
          end
        end else if (wait_inc == TMO) begin
          state_nxt = ST_RESP;
          rsp_load  = 1'b1;
          rsp_err   = 1'b1;
        end else begin
          wait_nxt = wait_inc;
        end
      end
      ST_RESP: begin
        if (!dpo_full_i) state_nxt = ST_PUSH;
      end
      ST_PUSH: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Response word assembled from the request address and the bus result
  always_comb begin
    rsp_word = '0;
    rsp_word[RSP_ERR_BIT]            = rsp_err;
    rsp_word[CMD_ADR_HI:CMD_ADR_LO]  = wb_adr_o;
    rsp_word[CMD_DAT_HI:CMD_DAT_LO]  = rsp_err ? 16'h0000 : wb_dat_i;
  end

  // State and wait-counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Registered outputs, decoded from the state being entered
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dpi_rd_o  <= 1'b0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      dpo_wr_o  <= 1'b0;
      dpo_dt_o  <= '0;
      busy_o    <= 1'b0;
      err_cnt_o <= '0;
    end else begin
      dpi_rd_o <= (state_nxt == ST_FETCH);
      wb_cyc_o <= (state_nxt == ST_WB);
      wb_stb_o <= (state_nxt == ST_WB);
      dpo_wr_o <= (state_nxt == ST_PUSH);
      busy_o   <= (state_nxt != ST_IDLE);
      if (state == ST_LATCH) begin
        wb_we_o  <= dpi_dt_i[CMD_WE_BIT];
        wb_adr_o <= dpi_dt_i[CMD_ADR_HI:CMD_ADR_LO];
        wb_dat_o <= dpi_dt_i[CMD_DAT_HI:CMD_DAT_LO];
      end
      if (rsp_load) begin
        dpo_dt_o <= rsp_word;
        if (rsp_err && (err_cnt_o != 16'hFFFF)) err_cnt_o <= err_cnt_o + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_dpi_cmd_dec.sv
// Bench for dpi_cmd_dec: behavioural FIFO, Wishbone slave and output monitor
// around the decoder; directed scenarios followed by randomized commands
// checked against a transaction-level model.
module tb_dpi_cmd_dec;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dpi_empty_i = 1'b1;
  logic        dpi_rd_o;
  logic [31:0] dpi_dt_i = '0;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [14:0] wb_adr_o;
  logic [15:0] wb_dat_o;
  logic [15:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic        dpo_full_i = 1'b0;
  logic        dpo_wr_o;
  logic [31:0] dpo_dt_o;
  logic        busy_o;
  logic [15:0] err_cnt_o;

  int total = 0;
  int bad   = 0;

  // input FIFO contents, consumed through rd_idx
  logic [31:0] in_q[$];
  int          rd_idx = 0;

  // slave behaviour for the current command
  int          sl_delay = 0;
  bit          sl_resp  = 1'b1;
  bit          sl_err   = 1'b0;
  bit          sl_both  = 1'b0;
  logic [15:0] sl_rdata = '0;
  int          sl_cnt   = 0;
  int          full_until = 0;

  // monitor records
  int          cyc = 0;
  int          stb_cnt = 0;
  int          unstable_cnt = 0;
  int          wr_full_cnt = 0;
  int          empty_fall_cyc = 0;
  int          full_fall_cyc = 0;
  int          wr_cyc = 0;
  bit          prev_empty = 1'b1, prev_full = 1'b0, prev_busy = 1'b0, prev_stb = 1'b0;
  int          rd_cyc_q[$];
  int          busy_fall_q[$];
  int          stb_rise_q[$];
  logic [31:0] stb_word_q[$];
  logic [31:0] out_q[$];
  logic [15:0] exp_errs = '0;

  dpi_cmd_dec #(.TIMEOUT(TMO)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .dpi_empty_i(dpi_empty_i),
    .dpi_rd_o   (dpi_rd_o),
    .dpi_dt_i   (dpi_dt_i),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack_i),
    .wb_err_i   (wb_err_i),
    .dpo_full_i (dpo_full_i),
    .dpo_wr_o   (dpo_wr_o),
    .dpo_dt_o   (dpo_dt_o),
    .busy_o     (busy_o),
    .err_cnt_o  (err_cnt_o)
  );

  always #5 clk = ~clk;

  // FIFO with one-cycle read latency; data bus carries junk when not read
  always @(posedge clk) begin
    if (dpi_rd_o && rd_idx < in_q.size()) begin
      dpi_dt_i <= in_q[rd_idx];
      rd_idx = rd_idx + 1;
    end else begin
      dpi_dt_i <= $urandom;
    end
    dpi_empty_i <= (rd_idx >= in_q.size());
  end

  // Wishbone slave: answers in strobe cycle sl_delay+1, or never
  always @(negedge clk) begin
    if (wb_stb_o) begin
      if (sl_resp && sl_cnt == sl_delay) begin
        wb_ack_i = !sl_err || sl_both;
        wb_err_i = sl_err;
        wb_dat_i = sl_rdata;
      end else begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = 16'($urandom);
      end
      sl_cnt = sl_cnt + 1;
    end else begin
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      sl_cnt   = 0;
    end
  end

  // output FIFO full window
  always @(negedge clk) dpo_full_i = (cyc < full_until);

  // monitor, sampled just after each rising edge
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (prev_empty && !dpi_empty_i) empty_fall_cyc = cyc;
    prev_empty = dpi_empty_i;
    if (prev_full && !dpo_full_i) full_fall_cyc = cyc;
    prev_full = dpo_full_i;
    if (dpi_rd_o) rd_cyc_q.push_back(cyc);
    if (wb_stb_o) begin
      if (!prev_stb) begin
        stb_rise_q.push_back(cyc);
        stb_word_q.push_back({wb_we_o, wb_adr_o, wb_dat_o});
      end else if ({wb_we_o, wb_adr_o, wb_dat_o} !== stb_word_q[$]) begin
        unstable_cnt = unstable_cnt + 1;
      end
      if (!wb_cyc_o) unstable_cnt = unstable_cnt + 1;
      stb_cnt = stb_cnt + 1;
    end
    prev_stb = wb_stb_o;
    if (dpo_wr_o) begin
      out_q.push_back(dpo_dt_o);
      wr_cyc = cyc;
      if (dpo_full_i) wr_full_cnt = wr_full_cnt + 1;
    end
    if (prev_busy && !busy_o) busy_fall_q.push_back(cyc);
    prev_busy = busy_o;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] outs();
    return {dpi_rd_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
            dpo_wr_o, dpo_dt_o, busy_o, err_cnt_o};
  endfunction

  // Transaction-level expectation for one command
  function automatic void model(input logic [31:0] cmd, input int dly, input bit resp,
                                input bit err, input logic [15:0] rdat,
                                output int n_stb, output bit has_rsp,
                                output logic [31:0] rsp, output bit fail);
    bit hs;
    hs      = resp && (dly < TMO);
    n_stb   = hs ? dly + 1 : TMO;
    fail    = !hs || err;
    has_rsp = fail || !cmd[31];
    rsp     = fail ? {1'b1, cmd[30:16], 16'h0000} : {1'b0, cmd[30:16], rdat};
  endfunction

  task automatic wait_falls(input string tag, input int target);
    int n = 0;
    while (busy_fall_q.size() < target && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".done"}, busy_fall_q.size() >= target, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic set_slave(input int dly, input bit resp, input bit err, input bit both,
                           input logic [15:0] rdat);
    sl_delay = dly;
    sl_resp  = resp;
    sl_err   = err;
    sl_both  = both;
    sl_rdata = rdat;
  endtask

  task automatic do_cmd(input string tag, input logic [31:0] w, input int dly, input bit resp,
                        input bit err, input bit both, input logic [15:0] rdat, input int stall);
    int n_stb;
    bit has_rsp;
    logic [31:0] rsp;
    bit fail;
    int b_stb, b_out, b_rd, b_fall, b_rise, b_unst, b_wf;
    model(w, dly, resp, err, rdat, n_stb, has_rsp, rsp, fail);
    set_slave(dly, resp, err, both, rdat);
    b_stb  = stb_cnt;
    b_out  = out_q.size();
    b_rd   = rd_cyc_q.size();
    b_fall = busy_fall_q.size();
    b_rise = stb_rise_q.size();
    b_unst = unstable_cnt;
    b_wf   = wr_full_cnt;
    full_until = cyc + stall;
    in_q.push_back(w);
    wait_falls(tag, b_fall + 1);
    if (fail && exp_errs != 16'hFFFF) exp_errs = exp_errs + 16'd1;
    check({tag, ".rd_n"}, rd_cyc_q.size() - b_rd, 1);
    check({tag, ".stb_n"}, stb_cnt - b_stb, n_stb);
    check({tag, ".stb_word"}, stb_word_q[b_rise], w);
    check({tag, ".stable"}, unstable_cnt - b_unst, 0);
    check({tag, ".wr_full"}, wr_full_cnt - b_wf, 0);
    check({tag, ".rsp_n"}, out_q.size() - b_out, has_rsp);
    if (has_rsp) check({tag, ".rsp"}, out_q[b_out], rsp);
    check({tag, ".err_cnt"}, err_cnt_o, exp_errs);
  endtask

  initial begin
    int b_rd, b_fall, b_rise, b_stb, b_out, n, c0, wr0;
    logic [31:0] w;

    repeat (3) @(negedge clk);
    check("rst.outs", outs(), 0);
    rst = 1'b0;
    @(negedge clk);

    // two back-to-back writes, ack in the first strobe cycle
    set_slave(0, 1'b1, 1'b0, 1'b0, 16'h0000);
    b_rd = rd_cyc_q.size(); b_fall = busy_fall_q.size(); b_rise = stb_rise_q.size();
    b_stb = stb_cnt; b_out = out_q.size();
    in_q.push_back(32'h8012_ABCD);
    in_q.push_back(32'h8056_0001);
    wait_falls("wr", b_fall + 2);
    c0 = empty_fall_cyc;
    check("wr.stb_n", stb_cnt - b_stb, 2);
    check("wr.stb_word", stb_word_q[b_rise], 32'h8012_ABCD);
    check("wr.stb_word2", stb_word_q[b_rise + 1], 32'h8056_0001);
    check("wr.rd_cyc", rd_cyc_q[b_rd], c0 + 1);
    check("wr.stb_cyc", stb_rise_q[b_rise], c0 + 3);
    check("wr.idle_cyc", busy_fall_q[b_fall], c0 + 4);
    check("wr.rd2_cyc", rd_cyc_q[b_rd + 1], c0 + 5);
    check("wr.rsp_n", out_q.size() - b_out, 0);

    // read acked after 3 wait cycles
    do_cmd("rd", 32'h0034_0000, 3, 1'b1, 1'b0, 1'b0, 16'h5A5A, 0);
    check("rd.wr_cyc", wr_cyc, empty_fall_cyc + 8);

    // no answer: abort after TMO strobe cycles
    do_cmd("tmo", 32'h0001_0000, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 0);

    // ack in the very cycle the wait count would expire
    do_cmd("ack_edge", 32'h0002_0000, TMO - 1, 1'b1, 1'b0, 1'b0, 16'h1234, 0);

    // ack and err together on a write
    do_cmd("errprio", 32'h8007_1234, 1, 1'b1, 1'b1, 1'b1, 16'hFFFF, 0);

    // read response held off by a full output FIFO; second word queued behind it
    set_slave(0, 1'b1, 1'b0, 1'b0, 16'hC3C3);
    b_rd = rd_cyc_q.size(); b_fall = busy_fall_q.size(); b_out = out_q.size();
    full_until = cyc + 16;
    in_q.push_back(32'h0021_0000);
    in_q.push_back(32'h0099_0000);
    wait_falls("bp", b_fall + 1);
    wr0 = wr_cyc;
    c0 = empty_fall_cyc;
    check("bp.rsp_n", out_q.size() - b_out, 1);
    check("bp.rsp", out_q[b_out], 32'h0021_C3C3);
    check("bp.wr_full", wr_full_cnt, 0);
    check("bp.wr_at_release", wr0, full_fall_cyc);
    check("bp.stalled", wr0 > c0 + 8, 1);
    wait_falls("bp2", b_fall + 2);
    check("bp.rd_n", rd_cyc_q.size() - b_rd, 2);
    check("bp.rd_after_wr", rd_cyc_q[b_rd + 1] > wr0, 1);
    check("bp.rsp2", out_q[b_out + 1], 32'h0099_C3C3);
    check("bp.busy_while_full", busy_fall_q[b_fall] >= wr0, 1);

    // reset two strobe cycles into a transaction that never completes
    set_slave(0, 1'b0, 1'b0, 1'b0, 16'h0000);
    b_stb = stb_cnt; b_out = out_q.size();
    in_q.push_back(32'h0042_0000);
    n = 0;
    while (stb_cnt - b_stb < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("mid_rst.reached", stb_cnt - b_stb, 2);
    check("mid_rst.err_before", err_cnt_o, exp_errs);
    #2 rst = 1'b1;
    #1 check("mid_rst.outs", outs(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_errs = '0;
    repeat (5) @(negedge clk);
    check("mid_rst.stb_n", stb_cnt - b_stb, 2);
    check("mid_rst.rsp_n", out_q.size() - b_out, 0);
    check("mid_rst.busy", busy_o, 0);
    do_cmd("post_rst", 32'h0043_0000, 1, 1'b1, 1'b0, 1'b0, 16'h1111, 0);

    // randomized commands
    for (int i = 0; i < 40; i++) begin
      w = $urandom;
      do_cmd("rnd", w, $urandom_range(0, 10), $urandom_range(0, 3) != 0,
             $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)),
             16'($urandom), $urandom_range(0, 20));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
